// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the 16-bit access/ack memory bus and its two-master arbiter.
package mem_bus_pkg;

   localparam int ADDR_W = 19;
   localparam int DATA_W = 16;
   localparam int SEL_W  = 2;

   // One bus request as presented by a master (word address bits [19:1]).
   typedef struct packed {
      logic [ADDR_W:1]   addr;
      logic              wr_en;
      logic [DATA_W-1:0] data;
      logic [SEL_W-1:0]  bytesel;
   } mem_req_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_A = 2'd1,
      GRANT_B = 2'd2
   } arb_state_t;

   typedef enum logic {
      MASTER_A = 1'b0,
      MASTER_B = 1'b1
   } master_id_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Access/ack memory bus. The master modport is the requester's view, the
// slave modport is the responder's view.
interface mem_bus_if;
   import mem_bus_pkg::*;

   logic              access;
   logic              ack;
   logic [ADDR_W:1]   addr;
   logic              wr_en;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;
   logic [SEL_W-1:0]  bytesel;

   modport master (output access, addr, wr_en, data_in, bytesel,
                   input  ack, data_out);
   modport slave  (input  access, addr, wr_en, data_in, bytesel,
                   output ack, data_out);
endinterface

// File: rtl/mem_port_arbiter_watchdog.sv
// Cycle counter that flags an access which has waited TIMEOUT_CYCLES cycles.
// The first granted cycle sees a count of 0, so expiry lands in the
// TIMEOUT_CYCLES-th granted cycle.
module bus_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] count;

   // Count waiting cycles of the current grant; clear takes priority.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 16'd1;
      end
   end

   assign expired = (count == LAST_COUNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory slave between the instruction
// master (a) and the data master (b). A grant is held until the slave acks
// or the watchdog terminates the access with ERROR_DATA and a bus_error pulse.
module mem_port_arbiter
   import mem_bus_pkg::*;
#(
   parameter int unsigned       TIMEOUT_CYCLES = 255,
   parameter logic [DATA_W-1:0] ERROR_DATA     = 16'hffff
) (
   input  logic      clk,
   input  logic      reset_n,
   mem_bus_if.slave  a_m,
   mem_bus_if.slave  b_m,
   mem_bus_if.master s_m,
   output logic      bus_error
);

   arb_state_t state;
   master_id_t last_grant;

   logic     grant_a;
   logic     grant_b;
   logic     granted;
   logic     expired;
   logic     timeout;
   logic     done;
   logic     a_done;
   logic     b_done;
   mem_req_t req_a;
   mem_req_t req_b;
   mem_req_t req_sel;

   assign grant_a = (state == GRANT_A);
   assign grant_b = (state == GRANT_B);
   assign granted = grant_a | grant_b;

   // A slave ack in the expiry cycle wins over the timeout.
   assign timeout = granted & expired & ~s_m.ack;
   assign done    = granted & (s_m.ack | expired);
   assign a_done  = grant_a & done;
   assign b_done  = grant_b & done;

   bus_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (~granted | done),
      .enable  (granted & ~s_m.ack),
      .expired (expired)
   );

   // Arbitration FSM. The master just served never wins from its own ack
   // cycle because its access line is still high with a stale request.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         last_grant <= MASTER_B;
      end else begin
         case (state)
            IDLE: begin
               if (a_m.access && (!b_m.access || last_grant == MASTER_B)) begin
                  state <= GRANT_A;
               end else if (b_m.access) begin
                  state <= GRANT_B;
               end
            end
            GRANT_A: begin
               if (done) begin
                  last_grant <= MASTER_A;
                  state      <= b_m.access ? GRANT_B : IDLE;
               end
            end
            GRANT_B: begin
               if (done) begin
                  last_grant <= MASTER_B;
                  state      <= a_m.access ? GRANT_A : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign req_a = {a_m.addr, a_m.wr_en, a_m.data_in, a_m.bytesel};
   assign req_b = {b_m.addr, b_m.wr_en, b_m.data_in, b_m.bytesel};

   // Forward the granted master's request; the slave bus is all-zero in IDLE.
   always_comb begin
      req_sel = '0;
      if (grant_a) begin
         req_sel = req_a;
      end else if (grant_b) begin
         req_sel = req_b;
      end
   end

   assign s_m.access  = granted & ~timeout;
   assign s_m.addr    = req_sel.addr;
   assign s_m.wr_en   = req_sel.wr_en;
   assign s_m.data_in = req_sel.data;
   assign s_m.bytesel = req_sel.bytesel;

   assign a_m.ack      = a_done;
   assign a_m.data_out = a_done ? (timeout ? ERROR_DATA : s_m.data_out) : '0;
   assign b_m.ack      = b_done;
   assign b_m.data_out = b_done ? (timeout ? ERROR_DATA : s_m.data_out) : '0;

   assign bus_error = timeout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Inputs change 1 time unit after the
// rising edge and outputs are sampled 1 time unit later.
module tb_mem_port_arbiter;

   logic clk;
   logic reset_n;
   logic bus_error;
   int   errors;
   int   checks;
   logic a_pend;
   logic b_pend;

   mem_bus_if a_if ();
   mem_bus_if b_if ();
   mem_bus_if s_if ();

   mem_port_arbiter #(
      .TIMEOUT_CYCLES (4),
      .ERROR_DATA     (16'hffff)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .a_m       (a_if),
      .b_m       (b_if),
      .s_m       (s_if),
      .bus_error (bus_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A master must hold access until it has been acked.
   always @(negedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_pend <= 1'b0;
         b_pend <= 1'b0;
      end else begin
         if (a_pend && !a_if.access) begin
            errors++;
            $display("FAIL a_access_held: access=%b required=1", a_if.access);
         end
         if (b_pend && !b_if.access) begin
            errors++;
            $display("FAIL b_access_held: access=%b required=1", b_if.access);
         end
         a_pend <= a_if.access & ~a_if.ack;
         b_pend <= b_if.access & ~b_if.ack;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running");
      $fatal(1, "bench timeout");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      a_if.access = 0; a_if.addr = '0; a_if.wr_en = 0; a_if.data_in = '0; a_if.bytesel = '0;
      b_if.access = 0; b_if.addr = '0; b_if.wr_en = 0; b_if.data_in = '0; b_if.bytesel = '0;
      s_if.ack = 0; s_if.data_out = '0;
   endtask

   task automatic do_reset;
      reset_n = 1'b0;
      clear_inputs();
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      clear_inputs();
      a_if.access = 1; b_if.access = 1; a_if.addr = 19'h12345;
      s_if.ack = 1; s_if.data_out = 16'h5555;
      #1;
      checks++; if (s_if.access !== 1'b0) begin errors++; $display("FAIL rst_s_access: got %b want 0", s_if.access); end
      checks++; if (s_if.addr !== 19'h0) begin errors++; $display("FAIL rst_s_addr: got %h want 0", s_if.addr); end
      checks++; if (a_if.ack !== 1'b0) begin errors++; $display("FAIL rst_a_ack: got %b want 0", a_if.ack); end
      checks++; if (b_if.ack !== 1'b0) begin errors++; $display("FAIL rst_b_ack: got %b want 0", b_if.ack); end
      checks++; if (a_if.data_out !== 16'h0) begin errors++; $display("FAIL rst_a_data: got %h want 0", a_if.data_out); end
      checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL rst_bus_error: got %b want 0", bus_error); end
      clear_inputs();
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_only_a;
      tick(); // cycle 0
      a_if.access = 1; a_if.addr = 19'h7fff0; a_if.bytesel = 2'b11; #1;
      checks++; if (s_if.access !== 1'b0) begin errors++; $display("FAIL t1_s_access_c0: got %b want 0", s_if.access); end
      tick(); // cycle 1
      #1;
      checks++; if (s_if.access !== 1'b1) begin errors++; $display("FAIL t1_s_access_c1: got %b want 1", s_if.access); end
      checks++; if (s_if.addr !== 19'h7fff0) begin errors++; $display("FAIL t1_s_addr_c1: got %h want 7fff0", s_if.addr); end
      checks++; if (a_if.ack !== 1'b0) begin errors++; $display("FAIL t1_a_ack_c1: got %b want 0", a_if.ack); end
      checks++; if (a_if.data_out !== 16'h0) begin errors++; $display("FAIL t1_a_data_c1: got %h want 0", a_if.data_out); end
      tick(); // cycle 2
      s_if.ack = 1; s_if.data_out = 16'hea5b; #1;
      checks++; if (s_if.access !== 1'b1) begin errors++; $display("FAIL t1_s_access_c2: got %b want 1", s_if.access); end
      checks++; if (a_if.ack !== 1'b1) begin errors++; $display("FAIL t1_a_ack_c2: got %b want 1", a_if.ack); end
      checks++; if (a_if.data_out !== 16'hea5b) begin errors++; $display("FAIL t1_a_data_c2: got %h want ea5b", a_if.data_out); end
      checks++; if (b_if.ack !== 1'b0) begin errors++; $display("FAIL t1_b_ack_c2: got %b want 0", b_if.ack); end
      checks++; if (b_if.data_out !== 16'h0) begin errors++; $display("FAIL t1_b_data_c2: got %h want 0", b_if.data_out); end
      tick(); // cycle 3
      a_if.access = 0; s_if.ack = 0; s_if.data_out = '0; #1;
      checks++; if (s_if.access !== 1'b0) begin errors++; $display("FAIL t1_s_access_c3: got %b want 0", s_if.access); end
      checks++; if (a_if.ack !== 1'b0) begin errors++; $display("FAIL t1_a_ack_c3: got %b want 0", a_if.ack); end
   endtask

   task automatic test_simultaneous;
      do_reset();
      tick(); // cycle 0
      a_if.access = 1; a_if.addr = 19'h00111; b_if.access = 1; b_if.addr = 19'h00222; #1;
      checks++; if (s_if.access !== 1'b0) begin errors++; $display("FAIL t2_s_access_c0: got %b want 0", s_if.access); end
      tick(); // cycle 1: A wins the first tie
      #1;
      checks++; if (s_if.addr !== 19'h00111) begin errors++; $display("FAIL t2_first_grant_addr: got %h want 00111", s_if.addr); end
      tick(); // cycle 2
      s_if.ack = 1; s_if.data_out = 16'h1111; #1;
      checks++; if (a_if.ack !== 1'b1) begin errors++; $display("FAIL t2_a_ack: got %b want 1", a_if.ack); end
      checks++; if (b_if.ack !== 1'b0) begin errors++; $display("FAIL t2_b_ack_c2: got %b want 0", b_if.ack); end
      tick(); // cycle 3: straight into GRANT_B
      a_if.access = 0; s_if.ack = 0; s_if.data_out = '0; #1;
      checks++; if (s_if.access !== 1'b1) begin errors++; $display("FAIL t2_no_bubble_access: got %b want 1", s_if.access); end
      checks++; if (s_if.addr !== 19'h00222) begin errors++; $display("FAIL t2_no_bubble_addr: got %h want 00222", s_if.addr); end
      tick(); // cycle 4
      s_if.ack = 1; s_if.data_out = 16'h2222; #1;
      checks++; if (b_if.ack !== 1'b1) begin errors++; $display("FAIL t2_b_ack: got %b want 1", b_if.ack); end
      checks++; if (b_if.data_out !== 16'h2222) begin errors++; $display("FAIL t2_b_data: got %h want 2222", b_if.data_out); end
      checks++; if (a_if.ack !== 1'b0) begin errors++; $display("FAIL t2_a_ack_c4: got %b want 0", a_if.ack); end
      tick(); // cycle 5
      b_if.access = 0; s_if.ack = 0; s_if.data_out = '0; #1;
      checks++; if (s_if.access !== 1'b0) begin errors++; $display("FAIL t2_idle_after: got %b want 0", s_if.access); end
   endtask

   task automatic test_alternate;
      logic             exp_a;
      logic [18:0]      exp_addr;
      logic [15:0]      exp_data;
      tick();
      a_if.access = 1; a_if.addr = 19'h00100; b_if.access = 1; b_if.addr = 19'h00201; #1;
      for (int k = 0; k < 5; k++) begin
         tick(); // grant cycle of transaction k
         s_if.ack = 0; s_if.data_out = '0;
         if (k > 0) begin
            if ((k - 1) % 2 == 0) a_if.addr = 19'h00100 + 19'(k + 1);
            else if (k == 4) b_if.access = 0;
            else b_if.addr = 19'h00200 + 19'(k + 1);
         end
         #1;
         exp_a    = (k % 2 == 0);
         exp_addr = exp_a ? 19'h00100 + 19'(k) : 19'h00200 + 19'(k);
         checks++; if (s_if.addr !== exp_addr) begin errors++; $display("FAIL t3_grant_addr_%0d: got %h want %h", k, s_if.addr, exp_addr); end
         tick(); // ack cycle of transaction k
         exp_data = 16'h3000 + 16'(k);
         s_if.ack = 1; s_if.data_out = exp_data; #1;
         if (exp_a) begin
            checks++; if (a_if.ack !== 1'b1 || a_if.data_out !== exp_data) begin errors++; $display("FAIL t3_a_ack_%0d: got ack=%b data=%h want ack=1 data=%h", k, a_if.ack, a_if.data_out, exp_data); end
            checks++; if (b_if.ack !== 1'b0) begin errors++; $display("FAIL t3_b_quiet_%0d: got %b want 0", k, b_if.ack); end
         end else begin
            checks++; if (b_if.ack !== 1'b1 || b_if.data_out !== exp_data) begin errors++; $display("FAIL t3_b_ack_%0d: got ack=%b data=%h want ack=1 data=%h", k, b_if.ack, b_if.data_out, exp_data); end
            checks++; if (a_if.ack !== 1'b0) begin errors++; $display("FAIL t3_a_quiet_%0d: got %b want 0", k, a_if.ack); end
         end
      end
      tick();
      a_if.access = 0; s_if.ack = 0; s_if.data_out = '0; #1;
      checks++; if (s_if.access !== 1'b0) begin errors++; $display("FAIL t3_idle_after: got %b want 0", s_if.access); end
   endtask

   task automatic test_write;
      tick(); // cycle 0
      b_if.access = 1; b_if.wr_en = 1; b_if.data_in = 16'h1234; b_if.bytesel = 2'b10; b_if.addr = 19'h00010; #1;
      checks++; if (s_if.wr_en !== 1'b0) begin errors++; $display("FAIL t4_idle_wr_en: got %b want 0", s_if.wr_en); end
      tick(); // cycle 1
      #1;
      checks++; if (s_if.wr_en !== 1'b1) begin errors++; $display("FAIL t4_wr_en: got %b want 1", s_if.wr_en); end
      checks++; if (s_if.data_in !== 16'h1234) begin errors++; $display("FAIL t4_data_in: got %h want 1234", s_if.data_in); end
      checks++; if (s_if.bytesel !== 2'b10) begin errors++; $display("FAIL t4_bytesel: got %b want 10", s_if.bytesel); end
      checks++; if (s_if.addr !== 19'h00010) begin errors++; $display("FAIL t4_addr: got %h want 00010", s_if.addr); end
      tick(); // cycle 2
      s_if.ack = 1; #1;
      checks++; if (b_if.ack !== 1'b1) begin errors++; $display("FAIL t4_b_ack: got %b want 1", b_if.ack); end
      checks++; if (s_if.wr_en !== 1'b1) begin errors++; $display("FAIL t4_wr_en_ack: got %b want 1", s_if.wr_en); end
      tick(); // cycle 3
      b_if.access = 0; b_if.wr_en = 0; b_if.data_in = '0; b_if.bytesel = '0; s_if.ack = 0; #1;
      checks++; if (s_if.data_in !== 16'h0) begin errors++; $display("FAIL t4_idle_data_in: got %h want 0", s_if.data_in); end
   endtask

   task automatic test_timeout;
      // Slave never answers.
      tick(); // cycle 0
      a_if.access = 1; a_if.addr = 19'h12345; #1;
      for (int c = 1; c <= 3; c++) begin
         tick();
         #1;
         checks++; if (s_if.access !== 1'b1 || a_if.ack !== 1'b0 || bus_error !== 1'b0) begin errors++; $display("FAIL t5_wait_c%0d: got access=%b ack=%b err=%b want 1 0 0", c, s_if.access, a_if.ack, bus_error); end
      end
      tick(); // cycle 4: fourth granted cycle
      s_if.data_out = 16'hbeef; #1;
      checks++; if (a_if.ack !== 1'b1) begin errors++; $display("FAIL t5_to_ack: got %b want 1", a_if.ack); end
      checks++; if (a_if.data_out !== 16'hffff) begin errors++; $display("FAIL t5_to_data: got %h want ffff", a_if.data_out); end
      checks++; if (bus_error !== 1'b1) begin errors++; $display("FAIL t5_to_bus_error: got %b want 1", bus_error); end
      checks++; if (s_if.access !== 1'b0) begin errors++; $display("FAIL t5_to_s_access: got %b want 0", s_if.access); end
      tick(); // cycle 5
      a_if.access = 0; s_if.data_out = '0; #1;
      checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL t5_err_pulse_end: got %b want 0", bus_error); end
      // Slave ack coincides with expiry.
      tick(); // cycle 0
      a_if.access = 1; a_if.addr = 19'h00abc; #1;
      for (int c = 1; c <= 3; c++) begin
         tick();
         #1;
      end
      tick(); // cycle 4
      s_if.ack = 1; s_if.data_out = 16'h5a5a; #1;
      checks++; if (a_if.ack !== 1'b1) begin errors++; $display("FAIL t5_race_ack: got %b want 1", a_if.ack); end
      checks++; if (a_if.data_out !== 16'h5a5a) begin errors++; $display("FAIL t5_race_data: got %h want 5a5a", a_if.data_out); end
      checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL t5_race_bus_error: got %b want 0", bus_error); end
      checks++; if (s_if.access !== 1'b1) begin errors++; $display("FAIL t5_race_s_access: got %b want 1", s_if.access); end
      tick(); // cycle 5: late ack while IDLE is ignored
      a_if.access = 0; s_if.ack = 1; s_if.data_out = 16'h6666; #1;
      checks++; if (a_if.ack !== 1'b0 || b_if.ack !== 1'b0) begin errors++; $display("FAIL t5_late_ack: got a=%b b=%b want 0 0", a_if.ack, b_if.ack); end
      tick();
      s_if.ack = 0; s_if.data_out = '0; #1;
   endtask

   task automatic test_reset_mid;
      tick(); // cycle 0
      b_if.access = 1; b_if.addr = 19'h00777; #1;
      tick(); // cycle 1: GRANT_B
      #1;
      checks++; if (s_if.access !== 1'b1) begin errors++; $display("FAIL t6_grant_b: got %b want 1", s_if.access); end
      #1;
      s_if.ack = 1; s_if.data_out = 16'h7777; reset_n = 1'b0; #1;
      checks++; if (s_if.access !== 1'b0) begin errors++; $display("FAIL t6_async_s_access: got %b want 0", s_if.access); end
      checks++; if (s_if.addr !== 19'h0) begin errors++; $display("FAIL t6_async_s_addr: got %h want 0", s_if.addr); end
      checks++; if (b_if.ack !== 1'b0) begin errors++; $display("FAIL t6_async_b_ack: got %b want 0", b_if.ack); end
      checks++; if (b_if.data_out !== 16'h0) begin errors++; $display("FAIL t6_async_b_data: got %h want 0", b_if.data_out); end
      s_if.ack = 0; s_if.data_out = '0;
      a_if.access = 1; a_if.addr = 19'h00555; b_if.addr = 19'h00666;
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      tick(); // first edge out of reset
      #1;
      checks++; if (s_if.addr !== 19'h00555) begin errors++; $display("FAIL t6_a_first: got %h want 00555", s_if.addr); end
      tick();
      s_if.ack = 1; s_if.data_out = 16'h0a0a; #1;
      checks++; if (a_if.ack !== 1'b1) begin errors++; $display("FAIL t6_a_ack: got %b want 1", a_if.ack); end
      tick();
      a_if.access = 0; s_if.ack = 0; s_if.data_out = '0; #1;
      checks++; if (s_if.addr !== 19'h00666) begin errors++; $display("FAIL t6_b_next: got %h want 00666", s_if.addr); end
      tick();
      s_if.ack = 1; s_if.data_out = 16'h0b0b; #1;
      checks++; if (b_if.ack !== 1'b1 || b_if.data_out !== 16'h0b0b) begin errors++; $display("FAIL t6_b_ack: got ack=%b data=%h want 1 0b0b", b_if.ack, b_if.data_out); end
      tick();
      b_if.access = 0; s_if.ack = 0; s_if.data_out = '0; #1;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_only_a();
      test_simultaneous();
      test_alternate();
      test_write();
      test_timeout();
      test_reset_mid();
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
